// File: rtl/crt_pkg.sv
// Shared constants for the CRT misc/status block: I/O bases, port offsets,
// the CR17 index and bit positions inside the Input Status registers.
package crt_pkg;

    localparam logic [15:0] MONO_BASE  = 16'h03B0;
    localparam logic [15:0] COLOR_BASE = 16'h03D0;

    localparam logic [15:0] OFF_IDX = 16'h0004;
    localparam logic [15:0] OFF_DAT = 16'h0005;
    localparam logic [15:0] OFF_STS = 16'h000A;

    localparam logic [5:0] CR17_IDX = 6'h17;

    // Input Status 0 field positions
    localparam int INS0_IRQ_POS   = 7;
    localparam int INS0_SENSE_POS = 4;

    // Input Status 1 field positions
    localparam int INS1_DE_POS    = 0;
    localparam int INS1_VSYNC_POS = 3;
    localparam int INS1_B4_POS    = 4;
    localparam int INS1_B5_POS    = 5;

    // Active I/O base for the current mono/colour decode
    function automatic logic [15:0] active_base(input logic color);
        return color ? COLOR_BASE : MONO_BASE;
    endfunction

endpackage

// File: rtl/crt_sync_edge.sv
// One-bit synchroniser followed by a rising-edge detector.
// The detector stays disarmed after reset until the pipeline has filled and
// the synchronised level has been seen low, so a level that is already high
// when reset releases is never reported as an edge.
module crt_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] fill_reg;
    logic                   prev_reg;
    logic                   armed_reg;

    // Synchroniser chain, pipeline-fill tracker, edge history and arming flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= '0;
            fill_reg  <= '0;
            prev_reg  <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], din};
            fill_reg  <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
            prev_reg  <= sync_reg[SYNC_STAGES-1];
            armed_reg <= armed_reg | (fill_reg[SYNC_STAGES-1] & ~sync_reg[SYNC_STAGES-1]);
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg & armed_reg;

endmodule

// File: rtl/crt_status_irq.sv
// CRT misc/status block: CR17, Feature Control, Input Status 0/1, plus
// edge-triggered interrupt sources with enable / write-1-to-clear pending
// registers and the attribute flip-flop clear pulse on Input Status 1 reads.
module crt_status_irq
    import crt_pkg::*;
#(
    parameter int          NUM_SRC      = 4,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [7:0]  EXT_IRQ_IDX  = 8'h50,
    parameter logic [15:0] EXT_DATA_ADR = 16'h03CF
) (
    input  logic               h_hclk,
    input  logic               h_reset,
    input  logic               color_mode,
    input  logic               h_io_16,
    input  logic               h_io_wr,
    input  logic               h_io_rd,
    input  logic [15:0]        h_addr,
    input  logic [15:0]        h_io_dbus,
    input  logic [5:0]         c_crtc_index,
    input  logic [7:0]         c_ext_index,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic               c_raw_vsync,
    input  logic               dis_en_sta,
    input  logic               t_sense_n,
    input  logic               a_is01_b5,
    input  logic               a_is01_b4,
    output logic [7:0]         reg_cr17,
    output logic [7:0]         reg_fcr,
    output logic [7:0]         reg_ins0,
    output logic [7:0]         reg_ins1,
    output logic [7:0]         reg_irq_en,
    output logic [7:0]         reg_irq_pend,
    output logic               crt_irq,
    output logic               attr_ff_clr,
    output logic               vsync_sel_ctl
);

    localparam logic [7:0] EXT_PEND_IDX = EXT_IRQ_IDX + 8'd1;

    logic [15:0]        base;
    logic               cr17_wr;
    logic               fcr_wr;
    logic               en_wr;
    logic               pend_wr;
    logic               is1_rd;

    logic [7:0]         cr17_reg;
    logic               fcr_b3_reg;
    logic [NUM_SRC-1:0] irq_en_reg;
    logic [NUM_SRC-1:0] irq_pend_reg;
    logic [NUM_SRC-1:0] irq_pend_next;
    logic               rd_prev_reg;
    logic               attr_clr_reg;

    logic [NUM_SRC-1:0] src_level;
    logic [NUM_SRC-1:0] src_rise;
    logic               vsync_s;
    logic               vsync_rise_unused;
    logic               unused_dbus;

    // Only a subset of the data bus bits is meaningful for these registers
    assign unused_dbus = ^{h_io_dbus, src_level, vsync_rise_unused};

    // One synchroniser / edge detector per interrupt source
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            crt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_src (
                .clk   (h_hclk),
                .rst   (h_reset),
                .din   (int_src[gi]),
                .level (src_level[gi]),
                .rise  (src_rise[gi])
            );
        end
    endgenerate

    // Raw vsync only needs its synchronised level for Input Status 1
    crt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vsync (
        .clk   (h_hclk),
        .rst   (h_reset),
        .din   (c_raw_vsync),
        .level (vsync_s),
        .rise  (vsync_rise_unused)
    );

    // Host I/O address decode against the active mono/colour base
    always_comb begin
        base    = active_base(color_mode);
        cr17_wr = h_io_wr && (c_crtc_index == CR17_IDX) &&
                  ((h_addr == base + OFF_DAT) || ((h_addr == base + OFF_IDX) && h_io_16));
        fcr_wr  = h_io_wr && (h_addr == base + OFF_STS);
        en_wr   = h_io_wr && (h_addr == EXT_DATA_ADR) && (c_ext_index == EXT_IRQ_IDX);
        pend_wr = h_io_wr && (h_addr == EXT_DATA_ADR) && (c_ext_index == EXT_PEND_IDX);
        is1_rd  = h_io_rd && (h_addr == base + OFF_STS);
    end

    // Pending update: write-1-to-clear first, then new edges, so a set wins
    always_comb begin
        irq_pend_next = irq_pend_reg;
        if (pend_wr)
            irq_pend_next = irq_pend_next & ~h_io_dbus[NUM_SRC+7:8];
        irq_pend_next = irq_pend_next | src_rise;
    end

    // Host-visible control registers, interrupt state and the IS1 read pulse
    always_ff @(posedge h_hclk or posedge h_reset) begin
        if (h_reset) begin
            cr17_reg     <= 8'h00;
            fcr_b3_reg   <= 1'b0;
            irq_en_reg   <= '0;
            irq_pend_reg <= '0;
            rd_prev_reg  <= 1'b0;
            attr_clr_reg <= 1'b0;
        end else begin
            if (cr17_wr)
                cr17_reg <= {h_io_dbus[15:13], 1'b0, h_io_dbus[11:8]};
            if (fcr_wr)
                fcr_b3_reg <= h_io_dbus[3];
            if (en_wr)
                irq_en_reg <= h_io_dbus[NUM_SRC+7:8];
            irq_pend_reg <= irq_pend_next;
            // Re-arm only after the read strobe has been low for a cycle
            rd_prev_reg  <= h_io_rd;
            attr_clr_reg <= is1_rd & ~rd_prev_reg;
        end
    end

    // Status assembly; crt_irq depends only on registered state
    always_comb begin
        reg_ins0                 = 8'h00;
        reg_ins0[INS0_IRQ_POS]   = crt_irq;
        reg_ins0[INS0_SENSE_POS] = t_sense_n;
        reg_ins1                 = 8'h00;
        reg_ins1[INS1_DE_POS]    = dis_en_sta;
        reg_ins1[INS1_VSYNC_POS] = vsync_s;
        reg_ins1[INS1_B4_POS]    = a_is01_b4;
        reg_ins1[INS1_B5_POS]    = a_is01_b5;
    end

    assign crt_irq       = |(irq_pend_reg & irq_en_reg);
    assign reg_cr17      = cr17_reg;
    assign reg_fcr       = {4'b0000, fcr_b3_reg, 3'b000};
    assign vsync_sel_ctl = fcr_b3_reg;
    assign reg_irq_en    = 8'(irq_en_reg);
    assign reg_irq_pend  = 8'(irq_pend_reg);
    assign attr_ff_clr   = attr_clr_reg;

endmodule

// File: tb/tb_crt_status_irq.sv
// Directed bench for crt_status_irq: register writes, interrupt latency,
// masking, set-vs-clear priority, IS1 read pulse and mid-run reset.
module tb_crt_status_irq;

    logic        h_hclk = 1'b0;
    logic        h_reset = 1'b0;
    logic        color_mode = 1'b0;
    logic        h_io_16 = 1'b0;
    logic        h_io_wr = 1'b0;
    logic        h_io_rd = 1'b0;
    logic [15:0] h_addr = 16'h0000;
    logic [15:0] h_io_dbus = 16'h0000;
    logic [5:0]  c_crtc_index = 6'h00;
    logic [7:0]  c_ext_index = 8'h00;
    logic [3:0]  int_src = 4'h0;
    logic        c_raw_vsync = 1'b0;
    logic        dis_en_sta = 1'b1;
    logic        t_sense_n = 1'b1;
    logic        a_is01_b5 = 1'b1;
    logic        a_is01_b4 = 1'b0;
    logic [7:0]  reg_cr17, reg_fcr, reg_ins0, reg_ins1, reg_irq_en, reg_irq_pend;
    logic        crt_irq, attr_ff_clr, vsync_sel_ctl;

    int tests = 0;
    int fails = 0;

    crt_status_irq dut (
        .h_hclk        (h_hclk),
        .h_reset       (h_reset),
        .color_mode    (color_mode),
        .h_io_16       (h_io_16),
        .h_io_wr       (h_io_wr),
        .h_io_rd       (h_io_rd),
        .h_addr        (h_addr),
        .h_io_dbus     (h_io_dbus),
        .c_crtc_index  (c_crtc_index),
        .c_ext_index   (c_ext_index),
        .int_src       (int_src),
        .c_raw_vsync   (c_raw_vsync),
        .dis_en_sta    (dis_en_sta),
        .t_sense_n     (t_sense_n),
        .a_is01_b5     (a_is01_b5),
        .a_is01_b4     (a_is01_b4),
        .reg_cr17      (reg_cr17),
        .reg_fcr       (reg_fcr),
        .reg_ins0      (reg_ins0),
        .reg_ins1      (reg_ins1),
        .reg_irq_en    (reg_irq_en),
        .reg_irq_pend  (reg_irq_pend),
        .crt_irq       (crt_irq),
        .attr_ff_clr   (attr_ff_clr),
        .vsync_sel_ctl (vsync_sel_ctl)
    );

    always #5 h_hclk = ~h_hclk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge h_hclk);
            #1;
        end
    endtask

    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        h_addr    = a;
        h_io_dbus = d;
        h_io_wr   = 1'b1;
        tick();
        h_io_wr   = 1'b0;
        h_addr    = 16'h0000;
        h_io_dbus = 16'h0000;
        $display("[TB] wr addr=%h data=%h", a, d);
    endtask

    task automatic test_reset;
        h_reset = 1'b1;
        tick(2);
        tests++;
        if ({reg_cr17, reg_fcr, reg_irq_en, reg_irq_pend} !== 32'h0) begin
            $display("FAIL reset_regs: got %h expected 00000000", {reg_cr17, reg_fcr, reg_irq_en, reg_irq_pend});
            fails++;
        end
        tests++;
        if ({crt_irq, attr_ff_clr, vsync_sel_ctl} !== 3'b000) begin
            $display("FAIL reset_bits: got %b expected 000", {crt_irq, attr_ff_clr, vsync_sel_ctl});
            fails++;
        end
        tests++;
        if ({reg_ins0, reg_ins1} !== 16'h1021) begin
            $display("FAIL reset_ins: got %h expected 1021", {reg_ins0, reg_ins1});
            fails++;
        end
        h_reset = 1'b0;
        tick(5);
        $display("[TB] reset checked");
    endtask

    task automatic test_cr17;
        color_mode   = 1'b1;
        c_crtc_index = 6'h17;
        io_write(16'h03D5, 16'hFF00);
        tests++;
        if (reg_cr17 !== 8'hEF) begin
            $display("FAIL cr17_color: got %h expected ef", reg_cr17);
            fails++;
        end
        io_write(16'h03B5, 16'h0000);
        tests++;
        if (reg_cr17 !== 8'hEF) begin
            $display("FAIL cr17_inactive_base: got %h expected ef", reg_cr17);
            fails++;
        end
        c_crtc_index = 6'h11;
        io_write(16'h03D5, 16'h0000);
        tests++;
        if (reg_cr17 !== 8'hEF) begin
            $display("FAIL cr17_other_index: got %h expected ef", reg_cr17);
            fails++;
        end
    endtask

    task automatic test_mono_fcr;
        color_mode   = 1'b0;
        h_io_16      = 1'b1;
        c_crtc_index = 6'h17;
        io_write(16'h03B4, 16'hA500);
        tests++;
        if (reg_cr17 !== 8'hA5) begin
            $display("FAIL cr17_mono16: got %h expected a5", reg_cr17);
            fails++;
        end
        h_io_16 = 1'b0;
        io_write(16'h03BA, 16'h0008);
        tests++;
        if ({reg_fcr, vsync_sel_ctl} !== {8'h08, 1'b1}) begin
            $display("FAIL fcr_write: got %h/%b expected 08/1", reg_fcr, vsync_sel_ctl);
            fails++;
        end
        io_write(16'h03DA, 16'h0000);
        tests++;
        if (reg_fcr !== 8'h08) begin
            $display("FAIL fcr_inactive_base: got %h expected 08", reg_fcr);
            fails++;
        end
    endtask

    task automatic test_status;
        c_raw_vsync = 1'b1;
        tick(2);
        tests++;
        if (reg_ins1 !== 8'h29) begin
            $display("FAIL ins1_vsync: got %h expected 29", reg_ins1);
            fails++;
        end
        c_raw_vsync = 1'b0;
        tick(3);
        $display("[TB] status checked");
    endtask

    task automatic test_irq_latency;
        c_ext_index = 8'h50;
        io_write(16'h03CF, 16'h0100);
        tests++;
        if (reg_irq_en !== 8'h01) begin
            $display("FAIL en_write: got %h expected 01", reg_irq_en);
            fails++;
        end
        int_src[0] = 1'b1;
        tick(2);
        tests++;
        if ({reg_irq_pend, crt_irq} !== {8'h00, 1'b0}) begin
            $display("FAIL irq_early: got %h/%b expected 00/0", reg_irq_pend, crt_irq);
            fails++;
        end
        tick();
        tests++;
        if ({reg_irq_pend, crt_irq} !== {8'h01, 1'b1}) begin
            $display("FAIL irq_latency3: got %h/%b expected 01/1", reg_irq_pend, crt_irq);
            fails++;
        end
        c_ext_index = 8'h51;
        io_write(16'h03CF, 16'h0100);
        tests++;
        if ({reg_irq_pend, crt_irq} !== {8'h00, 1'b0}) begin
            $display("FAIL irq_w1c: got %h/%b expected 00/0", reg_irq_pend, crt_irq);
            fails++;
        end
        int_src[0] = 1'b0;
        tick(3);
    endtask

    task automatic test_mask;
        c_ext_index = 8'h50;
        io_write(16'h03CF, 16'h0000);
        int_src[2] = 1'b1;
        tick(3);
        tests++;
        if ({reg_irq_pend, crt_irq} !== {8'h04, 1'b0}) begin
            $display("FAIL mask_pend: got %h/%b expected 04/0", reg_irq_pend, crt_irq);
            fails++;
        end
        io_write(16'h03CF, 16'h0400);
        tests++;
        if (crt_irq !== 1'b1) begin
            $display("FAIL mask_enable: got %b expected 1", crt_irq);
            fails++;
        end
        c_ext_index = 8'h52;
        io_write(16'h03CF, 16'h0000);
        tests++;
        if ({reg_irq_en, reg_irq_pend} !== 16'h0404) begin
            $display("FAIL ext_other_idx: got %h expected 0404", {reg_irq_en, reg_irq_pend});
            fails++;
        end
        c_ext_index = 8'h51;
        io_write(16'h03CF, 16'h0400);
        int_src[2] = 1'b0;
        c_ext_index = 8'h50;
        io_write(16'h03CF, 16'h0000);
        tick(3);
    endtask

    task automatic test_set_wins;
        int_src[1] = 1'b1;
        tick(2);
        c_ext_index = 8'h51;
        io_write(16'h03CF, 16'h0200);
        tests++;
        if (reg_irq_pend !== 8'h02) begin
            $display("FAIL set_beats_w1c: got %h expected 02", reg_irq_pend);
            fails++;
        end
        io_write(16'h03CF, 16'h0200);
        tick(10);
        tests++;
        if (reg_irq_pend !== 8'h00) begin
            $display("FAIL held_level_once: got %h expected 00", reg_irq_pend);
            fails++;
        end
        int_src[1] = 1'b0;
        tick(3);
    endtask

    task automatic test_attr;
        int pulses;
        color_mode = 1'b1;
        h_addr     = 16'h03DA;
        h_io_rd    = 1'b1;
        pulses     = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (attr_ff_clr === 1'b1) pulses++;
        end
        h_io_rd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (attr_ff_clr === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 1) begin
            $display("FAIL attr_held_read: got %0d pulses expected 1", pulses);
            fails++;
        end
        h_io_rd = 1'b1;
        tick(2);
        h_io_rd = 1'b0;
        tests++;
        if (attr_ff_clr !== 1'b0) begin
            $display("FAIL attr_single_cycle: got %b expected 0", attr_ff_clr);
            fails++;
        end
        h_addr  = 16'h03BA;
        h_io_rd = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (attr_ff_clr === 1'b1) pulses++;
        end
        h_io_rd = 1'b0;
        h_addr  = 16'h0000;
        tests++;
        if (pulses != 0) begin
            $display("FAIL attr_inactive_base: got %0d pulses expected 0", pulses);
            fails++;
        end
        tick();
    endtask

    task automatic test_reset_mid;
        c_ext_index = 8'h50;
        io_write(16'h03CF, 16'h0100);
        int_src[0] = 1'b1;
        tick(3);
        tests++;
        if (crt_irq !== 1'b1) begin
            $display("FAIL pre_reset_irq: got %b expected 1", crt_irq);
            fails++;
        end
        #2;
        h_reset = 1'b1;
        #1;
        tests++;
        if ({reg_irq_pend, reg_irq_en, crt_irq} !== 17'h0) begin
            $display("FAIL async_reset: got %h/%h/%b expected 00/00/0", reg_irq_pend, reg_irq_en, crt_irq);
            fails++;
        end
        tick(2);
        h_reset = 1'b0;
        tick(8);
        tests++;
        if (reg_irq_pend !== 8'h00) begin
            $display("FAIL high_after_reset: got %h expected 00", reg_irq_pend);
            fails++;
        end
        int_src[0] = 1'b0;
        tick(3);
        int_src[0] = 1'b1;
        tick(3);
        tests++;
        if ({reg_irq_pend, crt_irq} !== {8'h01, 1'b0}) begin
            $display("FAIL rearm_after_reset: got %h/%b expected 01/0", reg_irq_pend, crt_irq);
            fails++;
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_cr17();
        test_mono_fcr();
        test_status();
        test_irq_latency();
        test_mask();
        test_set_wins();
        test_attr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
